// File: rtl/fb_arb_pkg.sv
// Shared types and default widths for the frame-buffer SRAM arbiter.
package fb_arb_pkg;

   localparam int FB_ADDR_W = 17;
   localparam int FB_DATA_W = 12;

   typedef enum logic [1:0] {
      GNT_IDLE,
      GNT_DISP,
      GNT_HOST_RD,
      GNT_WR_DRAIN
   } grant_e;

   typedef enum logic [1:0] {
      TAG_NONE,
      TAG_DISP,
      TAG_HOST
   } tag_e;

endpackage

// File: rtl/fb_wr_fifo.sv
// Posted-write FIFO: synchronous, wrap-bit pointers, head entry exposed.
module fb_wr_fifo
   import fb_arb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = FB_ADDR_W,
   parameter int DW    = FB_DATA_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [AW-1:0] push_addr,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic          full,
   output logic          empty,
   output logic [AW-1:0] head_addr,
   output logic [DW-1:0] head_data
);

   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;

   logic [AW+DW-1:0] mem [DEPTH];
   logic [PW-1:0]    wp;
   logic [PW-1:0]    rp;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop)  rp <= rp + 1'b1;
      end
   end

   // Storage needs no reset: reset empties the FIFO via the pointers.
   always_ff @(posedge clk) begin
      if (push) mem[wp[IW-1:0]] <= {push_addr, push_data};
   end

   assign empty = (wp == rp);
   assign full  = (wp[IW] != rp[IW]) &&
                  (wp[IW-1:0] == rp[IW-1:0]);

   assign {head_addr, head_data} = mem[rp[IW-1:0]];

endmodule

// File: rtl/fb_sram_arbiter.sv
// Frame-buffer SRAM arbiter: display > host read > posted-write drain.
// Optional ARB_STATS_EN adds a saturating host stall counter.
module fb_sram_arbiter
   import fb_arb_pkg::*;
#(
   parameter int ADDR_WIDTH  = FB_ADDR_W,
   parameter int DATA_WIDTH  = FB_DATA_W,
   parameter int WFIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  disp_req,
   input  logic [ADDR_WIDTH-1:0] disp_addr,
   output logic                  disp_rvalid,
   output logic [DATA_WIDTH-1:0] disp_rdata,
   input  logic                  host_wr_valid,
   output logic                  host_wr_ready,
   input  logic [ADDR_WIDTH-1:0] host_wr_addr,
   input  logic [DATA_WIDTH-1:0] host_wr_data,
   input  logic                  host_rd_valid,
   output logic                  host_rd_ready,
   input  logic [ADDR_WIDTH-1:0] host_rd_addr,
   output logic                  host_rd_rvalid,
   output logic [DATA_WIDTH-1:0] host_rd_rdata,
   output logic                  sram_we,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [DATA_WIDTH-1:0] sram_din,
   input  logic [DATA_WIDTH-1:0] sram_dout
`ifdef ARB_STATS_EN
   ,
   output logic [15:0]           host_stall_cnt,
   input  logic                  stats_clr
`endif
);

   grant_e state_q;
   grant_e state_d;
   tag_e   tag_s1;
   tag_e   tag_s2;

   logic                  full;
   logic                  empty;
   logic                  push;
   logic                  pop;
   logic [ADDR_WIDTH-1:0] head_addr;
   logic [DATA_WIDTH-1:0] head_data;

   fb_wr_fifo #(
      .DEPTH (WFIFO_DEPTH),
      .AW    (ADDR_WIDTH),
      .DW    (DATA_WIDTH)
   ) u_wfifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_addr (host_wr_addr),
      .push_data (host_wr_data),
      .pop       (pop),
      .full      (full),
      .empty     (empty),
      .head_addr (head_addr),
      .head_data (head_data)
   );

   // Host reads wait for an empty FIFO so they always see posted writes.
   always_comb begin
      state_d = GNT_IDLE;
      if (rst)
         state_d = GNT_IDLE;
      else if (disp_req)
         state_d = GNT_DISP;
      else if (host_rd_valid && empty)
         state_d = GNT_HOST_RD;
      else if (!empty)
         state_d = GNT_WR_DRAIN;
   end

   assign host_rd_ready = (state_d == GNT_HOST_RD);
   assign host_wr_ready = !full;
   assign push          = host_wr_valid && !full;
   assign pop           = (state_d == GNT_WR_DRAIN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= GNT_IDLE;
         tag_s2    <= TAG_NONE;
         sram_we   <= 1'b0;
         sram_addr <= '0;
         sram_din  <= '0;
      end else begin
         state_q <= state_d;
         tag_s2  <= tag_s1;
         sram_we <= 1'b0;
         unique case (state_d)
            GNT_DISP:     sram_addr <= disp_addr;
            GNT_HOST_RD:  sram_addr <= host_rd_addr;
            GNT_WR_DRAIN: begin
               sram_we   <= 1'b1;
               sram_addr <= head_addr;
               sram_din  <= head_data;
            end
            default: ;
         endcase
      end
   end

   // First tag stage is the registered grant, aligned with sram_addr.
   always_comb begin
      tag_s1 = TAG_NONE;
      unique case (state_q)
         GNT_DISP:    tag_s1 = TAG_DISP;
         GNT_HOST_RD: tag_s1 = TAG_HOST;
         default:     tag_s1 = TAG_NONE;
      endcase
   end

   assign disp_rvalid    = (tag_s2 == TAG_DISP);
   assign host_rd_rvalid = (tag_s2 == TAG_HOST);
   assign disp_rdata     = disp_rvalid    ? sram_dout : '0;
   assign host_rd_rdata  = host_rd_rvalid ? sram_dout : '0;

`ifdef ARB_STATS_EN
   logic stall;

   assign stall = (host_rd_valid && !host_rd_ready) ||
                  (host_wr_valid && !host_wr_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         host_stall_cnt <= '0;
      else if (stats_clr)
         host_stall_cnt <= '0;
      else if (stall && host_stall_cnt != 16'hFFFF)
         host_stall_cnt <= host_stall_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_fb_sram_arbiter.sv
// Directed bench for fb_sram_arbiter with a queue-based reference model.
module tb_fb_sram_arbiter;

   localparam int AW  = 17;
   localparam int DW  = 12;
   localparam int DEP = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          disp_req = 1'b0;
   logic [AW-1:0] disp_addr = '0;
   logic          disp_rvalid;
   logic [DW-1:0] disp_rdata;
   logic          host_wr_valid = 1'b0;
   logic          host_wr_ready;
   logic [AW-1:0] host_wr_addr = '0;
   logic [DW-1:0] host_wr_data = '0;
   logic          host_rd_valid = 1'b0;
   logic          host_rd_ready;
   logic [AW-1:0] host_rd_addr = '0;
   logic          host_rd_rvalid;
   logic [DW-1:0] host_rd_rdata;
   logic          sram_we;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_din;
   logic [DW-1:0] sram_dout = '0;
`ifdef ARB_STATS_EN
   logic [15:0]   host_stall_cnt;
   logic          stats_clr = 1'b0;
`endif

   int errors = 0;
   int checks = 0;

   fb_sram_arbiter dut (
      .clk            (clk),
      .rst            (rst),
      .disp_req       (disp_req),
      .disp_addr      (disp_addr),
      .disp_rvalid    (disp_rvalid),
      .disp_rdata     (disp_rdata),
      .host_wr_valid  (host_wr_valid),
      .host_wr_ready  (host_wr_ready),
      .host_wr_addr   (host_wr_addr),
      .host_wr_data   (host_wr_data),
      .host_rd_valid  (host_rd_valid),
      .host_rd_ready  (host_rd_ready),
      .host_rd_addr   (host_rd_addr),
      .host_rd_rvalid (host_rd_rvalid),
      .host_rd_rdata  (host_rd_rdata),
      .sram_we        (sram_we),
      .sram_addr      (sram_addr),
      .sram_din       (sram_din),
      .sram_dout      (sram_dout)
`ifdef ARB_STATS_EN
      ,
      .host_stall_cnt (host_stall_cnt),
      .stats_clr      (stats_clr)
`endif
   );

   always #5 clk = ~clk;

   // SRAM model: 1-cycle synchronous read
   logic [DW-1:0] sram_mem [0:(1<<AW)-1];
   logic [DW-1:0] gold     [0:(1<<AW)-1];

   always @(posedge clk) begin
      if (sram_we) sram_mem[sram_addr] <= sram_din;
      sram_dout <= sram_mem[sram_addr];
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Reference model
   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   wr_t           q[$];
   wr_t           w;
   int            r1k = 0, r2k = 0, g, sz;
   logic [DW-1:0] r1d = '0, r2d = '0;
   logic          ewe = 1'b0;
   logic [AW-1:0] ea = '0;
   logic [DW-1:0] ed = '0;

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_we", 32'(sram_we), 0);
         chk("rst_addr", 32'(sram_addr), 0);
         chk("rst_din", 32'(sram_din), 0);
         chk("rst_disp_rvalid", 32'(disp_rvalid), 0);
         chk("rst_host_rvalid", 32'(host_rd_rvalid), 0);
         chk("rst_rd_ready", 32'(host_rd_ready), 0);
         chk("rst_wr_ready", 32'(host_wr_ready), 1);
         q.delete();
         r1k = 0; r2k = 0; ewe = 1'b0; ea = '0; ed = '0;
      end else begin
         sz = q.size();
         if (disp_req)                     g = 1;
         else if (host_rd_valid && sz == 0) g = 2;
         else if (sz > 0)                  g = 3;
         else                              g = 0;
         chk("m_wr_ready", 32'(host_wr_ready), 32'(sz < DEP));
         chk("m_rd_ready", 32'(host_rd_ready), 32'(g == 2));
         chk("m_sram_we", 32'(sram_we), 32'(ewe));
         chk("m_sram_addr", 32'(sram_addr), 32'(ea));
         chk("m_sram_din", 32'(sram_din), 32'(ed));
         chk("m_disp_rvalid", 32'(disp_rvalid), 32'(r2k == 1));
         chk("m_host_rvalid", 32'(host_rd_rvalid), 32'(r2k == 2));
         chk("m_disp_rdata", 32'(disp_rdata),
             (r2k == 1) ? 32'(r2d) : 0);
         chk("m_host_rdata", 32'(host_rd_rdata),
             (r2k == 2) ? 32'(r2d) : 0);
         r2k = r1k;
         r2d = r1d;
         r1k = 0;
         ewe = 1'b0;
         case (g)
            1: begin
               r1k = 1; r1d = gold[disp_addr]; ea = disp_addr;
            end
            2: begin
               r1k = 2; r1d = gold[host_rd_addr]; ea = host_rd_addr;
            end
            3: begin
               w = q.pop_front();
               gold[w.a] = w.d;
               ewe = 1'b1; ea = w.a; ed = w.d;
            end
            default: ;
         endcase
         if (host_wr_valid && sz < DEP)
            q.push_back({host_wr_addr, host_wr_data});
      end
   end

   initial begin
      for (int i = 0; i < (1 << AW); i++) begin
         sram_mem[i] = '0;
         gold[i]     = '0;
      end
      sram_mem[17'h00010] = 12'hABC;
      gold[17'h00010]     = 12'hABC;
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Display read
      disp_req = 1'b1; disp_addr = 17'h00010;
      tick();
      disp_req = 1'b0;
      chk("t1_sram_addr", 32'(sram_addr), 32'h10);
      chk("t1_sram_we", 32'(sram_we), 0);
      tick();
      chk("t1_disp_rvalid", 32'(disp_rvalid), 1);
      chk("t1_disp_rdata", 32'(disp_rdata), 32'hABC);
      chk("t1_host_rvalid", 32'(host_rd_rvalid), 0);
      tick();

      // Posted writes held off by display traffic
      disp_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         disp_addr     = 17'(17'h100 + i);
         host_wr_valid = 1'b1;
         host_wr_addr  = 17'(i);
         host_wr_data  = 12'(12'h111 * (i + 1));
         chk("t2_wr_ready", 32'(host_wr_ready), 1);
         tick();
         chk("t2_no_we", 32'(sram_we), 0);
      end
      host_wr_valid = 1'b0;
      chk("t2_full", 32'(host_wr_ready), 0);
      tick();
      chk("t2_hold_we", 32'(sram_we), 0);
      chk("t2_hold_full", 32'(host_wr_ready), 0);
      disp_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t2_drain_we", 32'(sram_we), 1);
         chk("t2_drain_addr", 32'(sram_addr), 32'(i));
         chk("t2_drain_din", 32'(sram_din), 32'(12'h111 * (i + 1)));
      end
      tick();
      chk("t2_done_we", 32'(sram_we), 0);

      // Read-after-write ordering
      host_wr_valid = 1'b1;
      host_wr_addr  = 17'h1F000;
      host_wr_data  = 12'h5A5;
      tick();
      host_wr_valid = 1'b0;
      host_rd_valid = 1'b1;
      host_rd_addr  = 17'h1F000;
      #1 chk("t3_rd_blocked", 32'(host_rd_ready), 0);
      tick();
      chk("t3_rd_granted", 32'(host_rd_ready), 1);
      tick();
      host_rd_valid = 1'b0;
      for (int k = 0; k < 6 && !host_rd_rvalid; k++) tick();
      chk("t3_rvalid", 32'(host_rd_rvalid), 1);
      chk("t3_rdata", 32'(host_rd_rdata), 32'h5A5);
      tick();

      // Priority: display, then drain, then host read
      disp_req = 1'b1; disp_addr = 17'h200;
      host_wr_valid = 1'b1;
      host_wr_addr  = 17'h20;
      host_wr_data  = 12'h777;
      tick();
      host_wr_valid = 1'b0;
      disp_addr     = 17'h201;
      host_rd_valid = 1'b1;
      host_rd_addr  = 17'h00010;
      #1 chk("t4_disp_wins", 32'(host_rd_ready), 0);
      tick();
      chk("t4_disp0_ret", 32'(disp_rvalid), 1);
      disp_req = 1'b0;
      #1 chk("t4_drain_first", 32'(host_rd_ready), 0);
      tick();
      chk("t4_disp1_ret", 32'(disp_rvalid), 1);
      chk("t4_rd_granted", 32'(host_rd_ready), 1);
      tick();
      host_rd_valid = 1'b0;
      for (int k = 0; k < 6 && !host_rd_rvalid; k++) tick();
      chk("t4_rvalid", 32'(host_rd_rvalid), 1);
      chk("t4_rdata", 32'(host_rd_rdata), 32'hABC);
      tick();

      // Async reset with a read in flight
      host_rd_valid = 1'b1;
      host_rd_addr  = 17'h00010;
      tick();
      host_rd_valid = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("t5_async_addr", 32'(sram_addr), 0);
      chk("t5_async_rvalid", 32'(host_rd_rvalid), 0);
      chk("t5_async_wr_ready", 32'(host_wr_ready), 1);
      tick();
      chk("t5_dropped", 32'(host_rd_rvalid), 0);
      rst = 1'b0;
      tick();
      chk("t5_no_stale", 32'(host_rd_rvalid), 0);

      // Async reset while draining discards the FIFO
      disp_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         host_wr_valid = 1'b1;
         host_wr_addr  = 17'(17'h50 + i);
         host_wr_data  = 12'(12'hE00 + i);
         tick();
      end
      host_wr_valid = 1'b0;
      disp_req = 1'b0;
      tick();
      chk("t5_we_before", 32'(sram_we), 1);
      #1 rst = 1'b1;
      #1;
      chk("t5_we_async", 32'(sram_we), 0);
      chk("t5_ready_async", 32'(host_wr_ready), 1);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t5_flushed", 32'(sram_we), 0);
      end

`ifdef ARB_STATS_EN
      stats_clr = 1'b1;
      tick();
      stats_clr = 1'b0;
      chk("s_clr0", 32'(host_stall_cnt), 0);
      disp_req = 1'b1; host_rd_valid = 1'b1;
      repeat (10) tick();
      disp_req = 1'b0; host_rd_valid = 1'b0;
      chk("s_ten", 32'(host_stall_cnt), 10);
      stats_clr = 1'b1;
      tick();
      stats_clr = 1'b0;
      chk("s_clr", 32'(host_stall_cnt), 0);
      disp_req = 1'b1; host_rd_valid = 1'b1;
      repeat (65540) tick();
      disp_req = 1'b0; host_rd_valid = 1'b0;
      chk("s_sat", 32'(host_stall_cnt), 32'hFFFF);
      tick();
`endif

      tick();
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
